fft_bitrev_reorder: RTL and testbench
=====================================

// Module: fft_bitrev_reorder
// PURPOSE
//  Consumer end of the SDF FFT stage chain: takes the bit-reversed-order output stream of the last
//  stage and re-emits each frame in natural bin order (k = 0..FFT_N-1) over a valid/ready interface.
//  Ping-pong buffer of two FFT_N-deep complex banks: one bank fills while the other drains.
//  The input side has no backpressure, matching the free-running stage pipeline; the output side does.
// PARAMETERS
//  FFT_N   1024  transform length; power of two, >= 4; LOG2N = $clog2(FFT_N)
//  DATA_W  16    signed width of each real/imag component
// PORTS
//  clk        in   1       clock; all logic on posedge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       input sample present this cycle
//  in_re      in   DATA_W  signed real part; sample n of frame holds bin bitrev(n)
//  in_im      in   DATA_W  signed imag part
//  out_valid  out  1       output sample present
//  out_ready  in   1       sink accepts; transfer = out_valid & out_ready
//  out_re     out  DATA_W  real part of bin out_index
//  out_im     out  DATA_W  imag part of bin out_index
//  out_index  out  LOG2N   natural bin index k
//  out_last   out  1       high with k = FFT_N-1
//  overrun    out  1       sticky; an input frame was dropped
// BEHAVIOUR
//  - Reset: out_valid=0, out_re/out_im/out_index=0, out_last=0, overrun=0; both banks empty,
//    write index wr_n=0, read index rd_k=0, write bank=0. Reset mid-frame discards all buffered data.
//  - Write: each in_valid increments wr_n (mod FFT_N, wraps N-1 -> 0). Sample is stored at address
//    bitrev(wr_n) of the current write bank. At wr_n=N-1 the bank is marked full; write bank toggles.
//  - Frame admission decided at wr_n=0: if no empty bank, the whole frame is dropped. wr_n still
//    counts (alignment kept), nothing is written, overrun set on that cycle and held until rst.
//    A bank freed mid-frame is not used until the next wr_n=0.
//  - Read: drains the oldest full bank in order k=0..N-1; bank returns to empty on the transfer with
//    out_last=1. Banks drain in the order they filled.
//  - Latency: with read side idle, out_valid rises 2 cycles after the cycle carrying wr_n=N-1
//    (1 cycle bank-full flag, 1 cycle synchronous RAM read).
//  - Handshake: out_re/out_im/out_index/out_last stay stable while out_valid & !out_ready.
//    out_valid never drops without a transfer. With out_ready held high, one sample per cycle,
//    no bubbles within a frame or between back-to-back full banks.
//  - Simultaneous: bank completes fill in the same cycle the other bank's last sample transfers ->
//    both take effect; the freed bank is available for a frame starting the next cycle.
//  - Data passes unmodified; no arithmetic, no saturation. Bitrev = LOG2N-bit index reversal.
// CONFIGURATION
//  FFT_BITREV_REORDER_SOF_EN:
//   defined -> extra inputs/outputs: in_sof (in, 1) and sof_err (out, 1, sticky, reset 0).
//     in_valid & in_sof forces wr_n to 0 for that sample (frame restart). If wr_n != 0 at that moment,
//     the partial frame is abandoned (its bank stays empty, not passed to read side) and sof_err set.
//     in_sof without in_valid is ignored.
//   undefined -> no in_sof/sof_err ports; frame alignment purely by counting in_valid from reset.
// TESTING (FFT_N=8, DATA_W=16)
//  1 Feed 8 valid samples, re=bitrev(n)*100, im=-re, out_ready=1 -> out re=0,100,...,700 in order,
//    out_index 0..7, out_last on 700, out_valid first 2 cycles after 8th input.
//  2 Three frames back-to-back, out_ready=0 throughout -> frames 1,2 buffered, frame 3 dropped,
//    overrun=1; then out_ready=1 -> exactly 16 samples (frames 1,2), then out_valid=0.
//  3 Random out_ready (50%) during continuous input at 1 frame/16 cycles -> all samples correct,
//    outputs stable while stalled, overrun stays 0.
//  4 Assert rst mid-frame (after 5 inputs, 3 outputs pending) -> all outputs 0 next cycle; fresh frame
//    after reset reorders correctly with no stale data.
//  5 Gapped input (in_valid 1 of 3 cycles) -> output identical to scenario 1, only timing differs.
//  6 SOF_EN defined: 3 samples then in_sof with new frame -> sof_err=1, only the new frame emitted.

Source files
------------

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: re-emits bit-reversed-order FFT frames in natural bin order.
// Two FFT_N-deep banks form a ping-pong buffer: one fills while the other drains.
// Optional build macro FFT_BITREV_REORDER_SOF_EN adds in_sof / sof_err frame restart.
module fft_bitrev_reorder #(
   parameter int unsigned FFT_N  = 1024,
   parameter int unsigned DATA_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic signed [DATA_W-1:0]   in_re,
   input  logic signed [DATA_W-1:0]   in_im,
`ifdef FFT_BITREV_REORDER_SOF_EN
   input  logic                       in_sof,
   output logic                       sof_err,
`endif
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [DATA_W-1:0]   out_re,
   output logic signed [DATA_W-1:0]   out_im,
   output logic [$clog2(FFT_N)-1:0]   out_index,
   output logic                       out_last,
   output logic                       overrun
);

   localparam int unsigned LOG2N = $clog2(FFT_N);
   localparam int unsigned SW    = 2 * DATA_W;
   localparam int unsigned AW    = LOG2N + 1;
   localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(FFT_N - 1);

   logic [SW-1:0]    mem [2*FFT_N];

   logic [LOG2N-1:0] wr_n;
   logic [LOG2N-1:0] rd_k;
   logic             wr_bank;
   logic             f_bank;
   logic             out_bank;
   logic             frame_ok;
   logic [1:0]       full;

   logic [LOG2N-1:0] wr_idx_c;
   logic [LOG2N-1:0] wr_rev_c;
   logic [1:0]       full_nxt_c;
   logic             restart_c;
   logic             admit_c;
   logic             wr_en_c;
   logic             wr_done_c;
   logic             load_c;
   logic             fetch_c;
   logic             drain_c;

   // Write-side index, admission, bit reversal and handshake decode
   always_comb begin
      restart_c = 1'b0;
`ifdef FFT_BITREV_REORDER_SOF_EN
      restart_c = in_valid & in_sof;
`endif
      wr_idx_c  = restart_c ? '0 : wr_n;
      wr_rev_c  = '0;
      for (int i = 0; i < int'(LOG2N); i++) begin
         wr_rev_c[i] = wr_idx_c[int'(LOG2N) - 1 - i];
      end
      admit_c   = (wr_idx_c == '0) ? ~full[wr_bank] : frame_ok;
      wr_en_c   = in_valid & admit_c;
      wr_done_c = wr_en_c & (wr_idx_c == LAST_IDX);
      load_c    = ~out_valid | out_ready;
      fetch_c   = load_c & full[f_bank];
      drain_c   = out_valid & out_ready & out_last;
      full_nxt_c = full;
      if (drain_c) begin
         full_nxt_c[out_bank] = 1'b0;
      end
      if (wr_done_c) begin
         full_nxt_c[wr_bank] = 1'b1;
      end
   end

   // Write counter, frame admission, bank flags and sticky error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_n     <= '0;
         wr_bank  <= 1'b0;
         frame_ok <= 1'b0;
         full     <= '0;
         overrun  <= 1'b0;
`ifdef FFT_BITREV_REORDER_SOF_EN
         sof_err  <= 1'b0;
`endif
      end else begin
         full <= full_nxt_c;
         if (in_valid) begin
            wr_n <= wr_idx_c + LOG2N'(1);
            if (wr_idx_c == '0) begin
               frame_ok <= ~full[wr_bank];
               if (full[wr_bank]) begin
                  overrun <= 1'b1;
               end
            end
            if (wr_done_c) begin
               wr_bank <= ~wr_bank;
            end
`ifdef FFT_BITREV_REORDER_SOF_EN
            if (restart_c && (wr_n != '0)) begin
               sof_err <= 1'b1;
            end
`endif
         end
      end
   end

   // Sample storage at its natural bin address
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem[AW'({wr_bank, wr_rev_c})] <= {in_re, in_im};
      end
   end

   // Drain the oldest full bank; output register doubles as the RAM read stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_index <= '0;
         out_last  <= 1'b0;
         out_bank  <= 1'b0;
         rd_k      <= '0;
         f_bank    <= 1'b0;
      end else if (load_c) begin
         if (fetch_c) begin
            out_valid        <= 1'b1;
            {out_re, out_im} <= mem[AW'({f_bank, rd_k})];
            out_index        <= rd_k;
            out_last         <= (rd_k == LAST_IDX);
            out_bank         <= f_bank;
            rd_k             <= rd_k + LOG2N'(1);
            if (rd_k == LAST_IDX) begin
               f_bank <= ~f_bank;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder at FFT_N=8: directed scenarios plus a frame-level reference model.
module tb_fft_bitrev_reorder;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_re = '0;
   logic [15:0] in_im = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [15:0] out_re;
   logic [15:0] out_im;
   logic [2:0]  out_index;
   logic        out_last;
   logic        overrun;
`ifdef FFT_BITREV_REORDER_SOF_EN
   logic        in_sof = 1'b0;
   logic        sof_err;
`endif

   fft_bitrev_reorder #(.FFT_N(N), .DATA_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
`ifdef FFT_BITREV_REORDER_SOF_EN
      .in_sof(in_sof), .sof_err(sof_err),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_index(out_index), .out_last(out_last), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int brev(input int v);
      int r = 0;
      int x = v;
      for (int i = 0; i < 3; i++) begin
         r = r * 2 + x % 2;
         x = x / 2;
      end
      return r;
   endfunction

   // Reference model: frames in arrival order, admitted while fewer than two are held
   logic [31:0] cur [N];
   logic [31:0] fr [2][N];
   int  head = 0, cnt = 0, mn = 0, rk = 0, xfers = 0;
   bit  m_adm = 0, exp_ovr = 0, exp_sof = 0, st_v = 0, pop;
   logic [36:0] st_val;

   always @(negedge clk) begin
      if (rst) begin
         head = 0; cnt = 0; mn = 0; rk = 0; m_adm = 0; exp_ovr = 0; exp_sof = 0; st_v = 0;
      end else begin
         chk("overrun", overrun, exp_ovr);
`ifdef FFT_BITREV_REORDER_SOF_EN
         chk("sof_err", sof_err, exp_sof);
`endif
         if (st_v)
            chk("stall_hold", {out_valid, out_re, out_im, out_index, out_last}, st_val);
         pop = 0;
         if (out_valid && out_ready) begin
            chk("xfer_has_frame", cnt > 0, 1);
            chk("out_index", out_index, rk);
            chk("out_data", {out_re, out_im}, fr[head][brev(rk)]);
            chk("out_last", out_last, rk == N - 1);
            pop = (rk == N - 1);
            rk = (rk + 1) % N;
            xfers++;
         end
         if (in_valid) begin
`ifdef FFT_BITREV_REORDER_SOF_EN
            if (in_sof) begin
               if (mn != 0) exp_sof = 1;
               mn = 0;
            end
`endif
            if (mn == 0) begin
               m_adm = (cnt < 2);
               if (!m_adm) exp_ovr = 1;
            end
            if (m_adm) cur[mn] = {in_re, in_im};
            if (mn == N - 1 && m_adm) begin
               for (int k = 0; k < N; k++) fr[(head + cnt) % 2][k] = cur[k];
               cnt++;
            end
            mn = (mn + 1) % N;
         end
         if (pop) begin
            head = (head + 1) % 2;
            cnt--;
         end
         st_v = out_valid && !out_ready;
         st_val = {out_valid, out_re, out_im, out_index, out_last};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] re, input logic [15:0] im);
      in_valid = 1'b1;
      in_re = re;
      in_im = im;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic drain(input int budget);
      out_ready = 1'b1;
      for (int i = 0; i < budget; i++) begin
         if (cnt == 0 && !out_valid) break;
         step();
      end
      chk("drain_done", (cnt == 0) && !out_valid, 1);
   endtask

   task automatic send_ramp_frame();
      logic [15:0] v;
      for (int n = 0; n < N; n++) begin
         v = 16'(brev(n) * 100);
         send(v, -v);
      end
   endtask

   initial begin
      logic [15:0] e16;
      int x0;

      // Reset state
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_re", out_re, 0);
      chk("rst_out_im", out_im, 0);
      chk("rst_out_index", out_index, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_overrun", overrun, 0);
      rst = 1'b0;
      step();

      // Single frame, natural order, 2-cycle latency
      out_ready = 1'b1;
      send_ramp_frame();
      @(negedge clk);
      chk("lat_not_yet", out_valid, 0);
      step();
      @(negedge clk);
      chk("lat_valid", out_valid, 1);
      for (int k = 0; k < N; k++) begin
         if (k > 0) @(negedge clk);
         e16 = 16'(k * 100);
         chk("t1_re", out_re, e16);
         e16 = -e16;
         chk("t1_im", out_im, e16);
         chk("t1_idx", out_index, k);
         chk("t1_last", out_last, k == N - 1);
      end
      @(negedge clk);
      chk("t1_idle", out_valid, 0);
      step();

      // Three frames with sink stalled: third dropped
      do_reset();
      out_ready = 1'b0;
      for (int n = 0; n < 3 * N; n++) send(16'($urandom), 16'($urandom));
      step();
      chk("t2_overrun", overrun, 1);
      x0 = xfers;
      out_ready = 1'b1;
      for (int i = 0; i < 30; i++) step();
      chk("t2_count", xfers - x0, 16);
      chk("t2_idle", out_valid, 0);

      // Half-rate input with random backpressure
      do_reset();
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 2 * N; i++) begin
            in_valid = (i % 2 == 0);
            in_re = 16'($urandom);
            in_im = 16'($urandom);
            out_ready = $urandom_range(0, 1) == 1;
            step();
         end
      end
      in_valid = 1'b0;
      drain(200);

      // Reset mid-frame with outputs pending
      do_reset();
      out_ready = 1'b0;
      for (int n = 0; n < N; n++) send(16'($urandom), 16'($urandom));
      out_ready = 1'b1;
      for (int n = 0; n < 5; n++) send(16'($urandom), 16'($urandom));
      rst = 1'b1;
      #1;
      chk("t4_valid", out_valid, 0);
      chk("t4_re", out_re, 0);
      chk("t4_im", out_im, 0);
      chk("t4_idx", out_index, 0);
      chk("t4_last", out_last, 0);
      step();
      rst = 1'b0;
      step();
      x0 = xfers;
      send_ramp_frame();
      drain(40);
      chk("t4_count", xfers - x0, N);

      // Gapped input
      do_reset();
      out_ready = 1'b1;
      x0 = xfers;
      for (int n = 0; n < N; n++) begin
         e16 = 16'(brev(n) * 100);
         send(e16, -e16);
         step();
         step();
      end
      drain(40);
      chk("t5_count", xfers - x0, N);

`ifdef FFT_BITREV_REORDER_SOF_EN
      // Restart mid-frame via in_sof
      do_reset();
      out_ready = 1'b1;
      x0 = xfers;
      for (int n = 0; n < 3; n++) send(16'($urandom), 16'($urandom));
      for (int n = 0; n < N; n++) begin
         in_sof = (n == 0);
         send(16'($urandom), 16'($urandom));
      end
      in_sof = 1'b0;
      drain(40);
      chk("t6_sof_err", sof_err, 1);
      chk("t6_count", xfers - x0, N);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
